// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: decodes MemRead/MemWrite codes, runs one access
// at a time on a single-port req/ack data bus, and stalls the pipeline until
// the access completes. Misaligned accesses are flagged without a bus cycle.
// Accesses that see no ack are aborted with an error after TIMEOUT cycles.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_Valid_i,
    input  logic [2:0]  MEM_MemRead_i,
    input  logic [1:0]  MEM_MemWrite_i,
    input  logic [31:0] MEM_Addr_i,
    input  logic [31:0] MEM_WData_i,
    output logic        Stall_o,
    output logic [31:0] RData_o,
    output logic        RData_valid_o,
    output logic        Err_o,
    output logic        Misalign_o,
    output logic        dm_req_o,
    output logic        dm_we_o,
    output logic [31:0] dm_addr_o,
    output logic [3:0]  dm_be_o,
    output logic [31:0] dm_wdata_o,
    input  logic        dm_ack_i,
    input  logic [31:0] dm_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  rd_type_q, rd_type_d;
    logic [1:0]  off_q, off_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] cnt_q, cnt_d;

    logic        is_store, is_load, op_present, misaligned, start;
    logic [1:0]  size;
    logic [1:0]  a;

    // Byte enables by access size and byte offset.
    function automatic logic [3:0] calc_be(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_W:    be = 4'b1111;
            SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b0001 << off;
        endcase
        return be;
    endfunction

    // Replicate store data across all lanes so the enabled lanes carry it.
    function automatic logic [31:0] calc_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        case (sz)
            SZ_W:    r = wd;
            SZ_H:    r = {2{wd[15:0]}};
            default: r = {4{wd[7:0]}};
        endcase
        return r;
    endfunction

    // Select the addressed lane of the read word and sign/zero extend it.
    function automatic logic [31:0] load_extend(input logic [2:0] rt, input logic [1:0] off,
                                                input logic [31:0] w);
        logic [31:0] shifted;
        logic [15:0] half;
        logic [31:0] r;
        shifted = w >> {off, 3'b000};
        half    = off[1] ? w[31:16] : w[15:0];
        case (rt)
            3'b010:  r = {{16{half[15]}}, half};
            3'b011:  r = {16'h0000, half};
            3'b100:  r = {{24{shifted[7]}}, shifted[7:0]};
            3'b101:  r = {24'h000000, shifted[7:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Decode the requested operation, its size and its alignment.
    always_comb begin
        a          = MEM_Addr_i[1:0];
        is_store   = (MEM_MemWrite_i != 2'b00);
        is_load    = !is_store && (MEM_MemRead_i >= 3'b001) && (MEM_MemRead_i <= 3'b101);
        op_present = is_store || is_load;
        size       = SZ_B;
        if (is_store) begin
            case (MEM_MemWrite_i)
                2'b01:   size = SZ_W;
                2'b10:   size = SZ_H;
                default: size = SZ_B;
            endcase
        end else begin
            case (MEM_MemRead_i)
                3'b001:         size = SZ_W;
                3'b010, 3'b011: size = SZ_H;
                default:        size = SZ_B;
            endcase
        end
        misaligned = ((size == SZ_W) && (a != 2'b00)) || ((size == SZ_H) && a[0]);
        start      = (state_q == IDLE) && MEM_Valid_i && op_present && !misaligned;
        Misalign_o = (state_q == IDLE) && MEM_Valid_i && op_present && misaligned;
    end

    // Next-state logic: launch in IDLE, wait for ack or timeout in REQ, report in DONE.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rd_type_d = rd_type_q;
        off_d     = off_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    req_d     = 1'b1;
                    we_d      = is_store;
                    addr_d    = {MEM_Addr_i[31:2], 2'b00};
                    be_d      = calc_be(size, a);
                    wdata_d   = is_store ? calc_wdata(size, MEM_WData_i) : 32'h0;
                    rd_type_d = is_store ? 3'b000 : MEM_MemRead_i;
                    off_d     = a;
                    err_d     = 1'b0;
                    cnt_d     = 16'h0000;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (dm_ack_i) begin
                    req_d   = 1'b0;
                    err_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = load_extend(rd_type_q, off_q, dm_rdata_i);
                    end
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and bus registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            be_q      <= 4'h0;
            wdata_q   <= 32'h0;
            rd_type_q <= 3'b000;
            off_q     <= 2'b00;
            err_q     <= 1'b0;
            rdata_q   <= 32'h0;
            cnt_q     <= 16'h0000;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rd_type_q <= rd_type_d;
            off_q     <= off_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
        end
    end

    // Output drive: bus fields come straight from the registered copies.
    always_comb begin
        Stall_o       = (state_q == REQ) || start;
        RData_valid_o = (state_q == DONE);
        Err_o         = (state_q == DONE) && err_q;
        RData_o       = rdata_q;
        dm_req_o      = req_q;
        dm_we_o       = we_q;
        dm_addr_o     = addr_q;
        dm_be_o       = be_q;
        dm_wdata_o    = wdata_q;
    end

endmodule
